block_a_plane_arbiter: RTL
==========================

// Module: block_a_plane_arbiter
// PURPOSE
// - Packet-level arbiter sharing block_a's single egress datapath between the control-plane and secure-data-plane inputs.
// - Control plane has priority. A burst limit prevents starvation of the secure plane.
// - A grant is held for a whole packet. A stall watchdog releases a grant whose source stops sending mid-packet.
// - Sits between the two ingress interfaces and block_a's egress stage; secure traffic is gated by a config enable.
// PARAMETERS
// - DATA_W          32   payload width of every port
// - MAX_CTRL_BURST  4    consecutive ctrl packets allowed while sec is waiting (>=1)
// - STALL_CYCLES    64   idle cycles inside a granted packet before forced release (>=2)
// PORTS
// - clk            in   1       single clock, rising edge
// - rst_n          in   1       asynchronous, active-low reset
// - ctrl_valid     in   1       control-plane beat valid
// - ctrl_data      in   DATA_W  control-plane beat
// - ctrl_last      in   1       final beat of control packet
// - ctrl_ready     out  1       control beat accepted when valid&ready
// - sec_valid/sec_data/sec_last/sec_ready  same roles for the secure data plane
// - sec_enable     in   1       0 = secure plane never granted
// - out_valid      out  1       egress beat valid
// - out_data       out  DATA_W  egress beat
// - out_last       out  1       egress end of packet
// - out_src        out  1       0 = ctrl, 1 = sec; valid with out_valid
// - out_ready      in   1       downstream accept
// - stall_err      out  1       one-cycle pulse on watchdog release
// - ctrl_pkt_cnt   out  16      saturating count of ctrl packets completed
// - sec_pkt_cnt    out  16      saturating count of sec packets completed
// BEHAVIOUR
// - Reset (async assert, sync release): state IDLE, streak=0, stall counter=0, both packet counters=0.
// - Reset values of outputs: all valid/ready outputs 0, stall_err 0, out_src 0.
// - FSM states: IDLE, GNT_CTRL, GNT_SEC. A grant is registered, so the first beat reaches egress one cycle after arrival at IDLE.
// - Grant decision in IDLE:
//   - sec_req = sec_valid & sec_enable.
//   - If ctrl_valid & sec_req & streak==MAX_CTRL_BURST -> GNT_SEC.
//   - Else if ctrl_valid -> GNT_CTRL.
//   - Else if sec_req -> GNT_SEC.
//   - Else stay in IDLE.
// - In GNT_x the selected input passes combinationally to the egress:
//   - out_valid = x_valid, out_data = x_data, out_last = x_last, x_ready = out_ready.
//   - The other input's ready is 0. In IDLE both readys are 0.
// - Packet completion and streak update:
//   - A packet completes on x_valid & out_ready & x_last: return to IDLE and increment that source's counter (saturating at 16'hFFFF).
//   - A completed ctrl packet increments streak (saturating at MAX_CTRL_BURST) only if sec_req was high at grant time. Otherwise streak is cleared.
//   - A completed sec packet clears streak.
// - Single-beat packets are legal: grant cycle then one transfer cycle; a new grant cannot be issued until the cycle after return to IDLE.
// - Watchdog:
//   - The stall counter increments each GNT_x cycle with x_valid==0 and clears on any x_valid==1 cycle or on leaving GNT_x. out_ready backpressure never counts.
//   - When the counter reaches STALL_CYCLES-1 with x_valid still 0: stall_err pulses next cycle, FSM goes to IDLE, and the packet counter is not incremented.
//   - Remaining beats of the aborted packet are re-arbitrated as a new packet.
// - sec_enable deasserted during GNT_SEC does not abort the packet; it only blocks new grants.
// - Reset mid-packet: immediate return to IDLE; partially transferred packets are not tracked.
// STRUCTURE
// - Package block_a_arb_pkg holds:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_CTRL, ARB_GNT_SEC} arb_state_t;
//   - typedef enum logic {SRC_CTRL=1'b0, SRC_SEC=1'b1} arb_src_t;
//   - localparam PKT_CNT_W = 16.
// - Sub-module block_a_stall_timer (params STALL_CYCLES; ports clk, rst_n, enable, activity, expire) implements the watchdog counter.
// - Everything else, FSM and counters included, lives in the top module.
// TESTING
// 1. ctrl only, three 4-beat packets, out_ready=1 -> 12 beats with out_src=0, one idle grant cycle between packets, ctrl_pkt_cnt=3.
// 2. ctrl and sec both valid continuously, MAX_CTRL_BURST=4, 1-beat packets -> grant order C,C,C,C,S,C,C,C,C,S; streak returns to 0 after each S.
// 3. sec_enable=0 with sec_valid=1 for 200 cycles, no ctrl -> sec_ready stays 0, out_valid stays 0, sec_pkt_cnt=0.
// 4. sec granted, sends 2 beats then drops valid for 64 cycles -> stall_err pulses once, FSM in IDLE, sec_pkt_cnt unchanged; a pending ctrl packet is granted next.
// 5. out_ready=0 for 100 cycles mid ctrl packet -> no stall_err, data held stable, packet completes when out_ready=1.
// 6. rst_n asserted mid sec packet and released after 3 cycles -> all outputs and both counters 0, FSM in IDLE, next request granted normally.

Source files
------------

// File: rtl/block_a_arb_pkg.sv
// Shared types and helpers for the block_a control/secure plane arbiter.
package block_a_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_GNT_CTRL = 2'd1,
        ARB_GNT_SEC  = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_CTRL = 1'b0,
        SRC_SEC  = 1'b1
    } arb_src_t;

    localparam int PKT_CNT_W = 16;

    function automatic logic [PKT_CNT_W-1:0] sat_inc(input logic [PKT_CNT_W-1:0] v);
        logic [PKT_CNT_W-1:0] r;
        if (v == {PKT_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + PKT_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/block_a_stall_timer.sv
// Watchdog counting idle cycles of a granted source; expire fires on the
// last tolerated idle cycle so the owner can release the grant at that edge.
module block_a_stall_timer #(
    parameter int STALL_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic activity,
    output logic expire
);

    localparam int CW = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(STALL_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next idle count and expiry; backpressure is not visible here by design.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (!enable || activity) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == LIMIT) begin
            expire = 1'b1;
            cnt_d  = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/block_a_plane_arbiter.sv
// Packet-level arbiter sharing block_a's egress between control and secure
// planes: ctrl priority, bounded ctrl bursts, whole-packet grants, stall release.
module block_a_plane_arbiter
    import block_a_arb_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int MAX_CTRL_BURST = 4,
    parameter int STALL_CYCLES   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ctrl_valid,
    input  logic [DATA_W-1:0]    ctrl_data,
    input  logic                 ctrl_last,
    output logic                 ctrl_ready,
    input  logic                 sec_valid,
    input  logic [DATA_W-1:0]    sec_data,
    input  logic                 sec_last,
    output logic                 sec_ready,
    input  logic                 sec_enable,
    output logic                 out_valid,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_last,
    output logic                 out_src,
    input  logic                 out_ready,
    output logic                 stall_err,
    output logic [PKT_CNT_W-1:0] ctrl_pkt_cnt,
    output logic [PKT_CNT_W-1:0] sec_pkt_cnt
);

    localparam int SW = $clog2(MAX_CTRL_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CTRL_BURST);

    arb_state_t           state_q, state_d;
    logic [SW-1:0]        streak_q, streak_d;
    logic                 sec_waited_q, sec_waited_d;
    logic                 stall_err_q, stall_err_d;
    logic [PKT_CNT_W-1:0] ctrl_cnt_q, ctrl_cnt_d;
    logic [PKT_CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic                 sec_req_s;
    logic                 gnt_valid_s;
    logic                 expire_s;

    assign sec_req_s   = sec_valid & sec_enable;
    assign gnt_valid_s = (state_q == ARB_GNT_CTRL) ? ctrl_valid :
                         (state_q == ARB_GNT_SEC)  ? sec_valid  : 1'b0;

    block_a_stall_timer #(
        .STALL_CYCLES(STALL_CYCLES)
    ) u_stall_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (state_q != ARB_IDLE),
        .activity(gnt_valid_s),
        .expire  (expire_s)
    );

    // Grant decision, packet completion, streak and counter updates.
    always_comb begin
        state_d      = state_q;
        streak_d     = streak_q;
        sec_waited_d = sec_waited_q;
        stall_err_d  = 1'b0;
        ctrl_cnt_d   = ctrl_cnt_q;
        sec_cnt_d    = sec_cnt_q;
        case (state_q)
            ARB_IDLE: begin
                if (ctrl_valid && sec_req_s && (streak_q == STREAK_MAX)) begin
                    state_d = ARB_GNT_SEC;
                end else if (ctrl_valid) begin
                    state_d      = ARB_GNT_CTRL;
                    sec_waited_d = sec_req_s;
                end else if (sec_req_s) begin
                    state_d = ARB_GNT_SEC;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GNT_CTRL: begin
                if (expire_s) begin
                    state_d     = ARB_IDLE;
                    stall_err_d = 1'b1;
                end else if (ctrl_valid && out_ready && ctrl_last) begin
                    state_d    = ARB_IDLE;
                    ctrl_cnt_d = sat_inc(ctrl_cnt_q);
                    // Streak only grows when the secure plane was actually kept waiting.
                    if (!sec_waited_q) begin
                        streak_d = {SW{1'b0}};
                    end else if (streak_q == STREAK_MAX) begin
                        streak_d = streak_q;
                    end else begin
                        streak_d = streak_q + SW'(1);
                    end
                end else begin
                    state_d = ARB_GNT_CTRL;
                end
            end
            ARB_GNT_SEC: begin
                if (expire_s) begin
                    state_d     = ARB_IDLE;
                    stall_err_d = 1'b1;
                end else if (sec_valid && out_ready && sec_last) begin
                    state_d   = ARB_IDLE;
                    sec_cnt_d = sat_inc(sec_cnt_q);
                    streak_d  = {SW{1'b0}};
                end else begin
                    state_d = ARB_GNT_SEC;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Egress mux: the granted source passes straight through.
    always_comb begin
        out_valid  = 1'b0;
        out_data   = {DATA_W{1'b0}};
        out_last   = 1'b0;
        out_src    = SRC_CTRL;
        ctrl_ready = 1'b0;
        sec_ready  = 1'b0;
        case (state_q)
            ARB_GNT_CTRL: begin
                out_valid  = ctrl_valid;
                out_data   = ctrl_data;
                out_last   = ctrl_last;
                ctrl_ready = out_ready;
            end
            ARB_GNT_SEC: begin
                out_valid = sec_valid;
                out_data  = sec_data;
                out_last  = sec_last;
                out_src   = SRC_SEC;
                sec_ready = out_ready;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    // State, streak and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            streak_q     <= {SW{1'b0}};
            sec_waited_q <= 1'b0;
            stall_err_q  <= 1'b0;
            ctrl_cnt_q   <= {PKT_CNT_W{1'b0}};
            sec_cnt_q    <= {PKT_CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            streak_q     <= streak_d;
            sec_waited_q <= sec_waited_d;
            stall_err_q  <= stall_err_d;
            ctrl_cnt_q   <= ctrl_cnt_d;
            sec_cnt_q    <= sec_cnt_d;
        end
    end

    assign stall_err    = stall_err_q;
    assign ctrl_pkt_cnt = ctrl_cnt_q;
    assign sec_pkt_cnt  = sec_cnt_q;

endmodule
